// File: rtl/uart_tx.sv
// uart_tx: 16550-style UART transmitter driven by an external baud tick.
// A holding stage feeds a transmit shift register that serialises one frame
// per byte: start bit, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop.
// Build option UART_TX_FIFO_EN: when defined the holding stage is a
// FIFO_DEPTH-entry circular FIFO; otherwise it is a single byte register.
module uart_tx #(
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       br,
   input  logic [7:0] thr_data,
   input  logic       thr_wr,
   input  logic [1:0] word_len,
   input  logic       stop_bits,
   input  logic       parity_en,
   input  logic       even_parity,
   input  logic       stick_parity,
   input  logic       break_ctrl,
   output logic       txd,
   output logic       thr_full,
   output logic       thr_empty,
   output logic       tsr_empty,
   output logic       tx_overrun
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } txState_t;

   // The tick counter must reach two full bit times for the longest stop phase.
   localparam int TICK_W = $clog2(2 * OVERSAMPLE);

   localparam logic [TICK_W-1:0] ONE_BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] ONE_HALF_LAST = TICK_W'((3 * OVERSAMPLE) / 2 - 1);
   localparam logic [TICK_W-1:0] TWO_BIT_LAST  = TICK_W'(2 * OVERSAMPLE - 1);

   // Reject parameter values the bit timing and pointer wrap cannot support.
   if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : gBadOversample
      $error("uart_tx: OVERSAMPLE must be even and at least 4");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadDepth
      $error("uart_tx: FIFO_DEPTH must be a power of two of at least 2");
   end

   txState_t          state;
   txState_t          stateNext;
   logic [TICK_W-1:0] tickCnt;
   logic [2:0]        bitCnt;
   logic [7:0]        tsr;
   logic              parAcc;
   logic              txdReg;

   logic [1:0]        cfgWordLen;
   logic              cfgStop;
   logic              cfgParEn;
   logic              cfgEven;
   logic              cfgStick;

   logic              holdFull;
   logic              holdEmpty;
   logic [7:0]        holdData;

   logic              loadTsr;
   logic              wrAccept;
   logic              bitEnd;
   logic              stopEnd;
   logic              lastData;
   logic              parityBit;
   logic [TICK_W-1:0] stopLast;

   // A write is taken when there is room, or when the shifter is pulling the
   // oldest byte out on this very edge and so frees a slot for it. Only a
   // write that finds no room and no simultaneous load is dropped.
   assign wrAccept   = thr_wr && (!holdFull || loadTsr);
   assign tx_overrun = thr_wr && holdFull && !loadTsr;

`ifdef UART_TX_FIFO_EN

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [7:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   fifoCount;

   // Storage array is written without reset; the pointers and count alone
   // decide which entries are live, so clearing them empties the FIFO.
   always_ff @(posedge clk) begin
      if (wrAccept) begin
         fifoMem[wrPtr] <= thr_data;
      end
   end

   // Pointers wrap naturally because the depth is a power of two. A push and
   // pop on the same edge leave the count unchanged, including when full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (wrAccept) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (loadTsr) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({wrAccept, loadTsr})
            2'b10:   fifoCount <= fifoCount + 1'b1;
            2'b01:   fifoCount <= fifoCount - 1'b1;
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   assign holdData  = fifoMem[rdPtr];
   assign holdFull  = (fifoCount == DEPTH_CNT);
   assign holdEmpty = (fifoCount == '0);

`else

   logic [7:0] thrReg;
   logic       thrValid;

   // Single holding register with a valid flag. A write that lands on the
   // same edge as a load replaces the byte being consumed, so valid stays set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         thrReg   <= '0;
         thrValid <= 1'b0;
      end else if (wrAccept) begin
         thrReg   <= thr_data;
         thrValid <= 1'b1;
      end else if (loadTsr) begin
         thrValid <= 1'b0;
      end
   end

   assign holdData  = thrReg;
   assign holdFull  = thrValid;
   assign holdEmpty = !thrValid;

`endif

   // Stop phase length in ticks comes from the configuration captured at load:
   // one bit, two bits, or one and a half bits for 5-bit words.
   always_comb begin
      stopLast = ONE_BIT_LAST;
      if (cfgStop) begin
         stopLast = (cfgWordLen == 2'b00) ? ONE_HALF_LAST : TWO_BIT_LAST;
      end
   end

   assign bitEnd    = br && (tickCnt == ONE_BIT_LAST);
   assign stopEnd   = br && (tickCnt == stopLast);
   assign lastData  = (bitCnt == (3'd4 + {1'b0, cfgWordLen}));
   assign parityBit = cfgStick ? !cfgEven : (cfgEven ? parAcc : !parAcc);

   // Frame sequencer next state. Leaving IDLE does not wait for a baud tick,
   // and the end of a stop phase chains straight into the next start bit when
   // another byte is already waiting, so consecutive frames have no gap.
   always_comb begin
      stateNext = state;
      loadTsr   = 1'b0;
      case (state)
         IDLE: begin
            if (!holdEmpty) begin
               loadTsr   = 1'b1;
               stateNext = START;
            end
         end
         START: begin
            if (bitEnd) begin
               stateNext = DATA;
            end
         end
         DATA: begin
            if (bitEnd && lastData) begin
               stateNext = cfgParEn ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bitEnd) begin
               stateNext = STOP;
            end
         end
         STOP: begin
            if (stopEnd) begin
               if (!holdEmpty) begin
                  loadTsr   = 1'b1;
                  stateNext = START;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Shift datapath. A load captures the byte plus its framing options and
   // drives the start bit on the same edge. Each later bit boundary drives the
   // next serial level, shifting the register right and folding every data
   // bit that goes out into the running parity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tickCnt    <= '0;
         bitCnt     <= '0;
         tsr        <= '0;
         parAcc     <= 1'b0;
         txdReg     <= 1'b1;
         cfgWordLen <= 2'b00;
         cfgStop    <= 1'b0;
         cfgParEn   <= 1'b0;
         cfgEven    <= 1'b0;
         cfgStick   <= 1'b0;
      end else if (loadTsr) begin
         tsr        <= holdData;
         cfgWordLen <= word_len;
         cfgStop    <= stop_bits;
         cfgParEn   <= parity_en;
         cfgEven    <= even_parity;
         cfgStick   <= stick_parity;
         tickCnt    <= '0;
         bitCnt     <= '0;
         parAcc     <= 1'b0;
         txdReg     <= 1'b0;
      end else begin
         if (br && (state != IDLE)) begin
            if ((state == STOP) ? stopEnd : bitEnd) begin
               tickCnt <= '0;
            end else begin
               tickCnt <= tickCnt + 1'b1;
            end
         end
         case (state)
            START: begin
               if (bitEnd) begin
                  txdReg <= tsr[0];
                  tsr    <= {1'b0, tsr[7:1]};
                  parAcc <= parAcc ^ tsr[0];
                  bitCnt <= '0;
               end
            end
            DATA: begin
               if (bitEnd) begin
                  if (lastData) begin
                     txdReg <= cfgParEn ? parityBit : 1'b1;
                  end else begin
                     txdReg <= tsr[0];
                     tsr    <= {1'b0, tsr[7:1]};
                     parAcc <= parAcc ^ tsr[0];
                     bitCnt <= bitCnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bitEnd) begin
                  txdReg <= 1'b1;
               end
            end
            default: begin
               txdReg <= txdReg;
            end
         endcase
      end
   end

   // Break forces the line low after the registered bit; the sequencer keeps
   // running underneath, so any frame sent during break is lost on the wire.
   assign txd       = txdReg && !break_ctrl;
   assign thr_full  = holdFull;
   assign thr_empty = holdEmpty;
   assign tsr_empty = (state == IDLE) && holdEmpty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a baud tick every 6 clocks.
// One serial bit therefore lasts 16 * 6 = 96 clocks.
module tb_uart_tx;

   localparam int OS       = 16;
   localparam int BR_DIV   = 6;
   localparam int BIT_CLKS = OS * BR_DIV;

   logic       clk;
   logic       rst_n;
   logic       br;
   logic [7:0] thr_data;
   logic       thr_wr;
   logic [1:0] word_len;
   logic       stop_bits;
   logic       parity_en;
   logic       even_parity;
   logic       stick_parity;
   logic       break_ctrl;
   logic       txd;
   logic       thr_full;
   logic       thr_empty;
   logic       tsr_empty;
   logic       tx_overrun;

   int   vectors;
   int   miscompares;
   int   brCnt;
   logic brSync;

   uart_tx #(.OVERSAMPLE(OS), .FIFO_DEPTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .br          (br),
      .thr_data    (thr_data),
      .thr_wr      (thr_wr),
      .word_len    (word_len),
      .stop_bits   (stop_bits),
      .parity_en   (parity_en),
      .even_parity (even_parity),
      .stick_parity(stick_parity),
      .break_ctrl  (break_ctrl),
      .txd         (txd),
      .thr_full    (thr_full),
      .thr_empty   (thr_empty),
      .tsr_empty   (tsr_empty),
      .tx_overrun  (tx_overrun)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Baud tick model: one-clock pulse every BR_DIV clocks, re-phased by brSync
   // so that the first tick after a load lands exactly 6 clocks later.
   always @(posedge clk) begin
      if (brSync || (brCnt == BR_DIV - 1)) brCnt <= 0;
      else brCnt <= brCnt + 1;
   end
   assign br = (brCnt == BR_DIV - 1);

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Write one byte from idle; returns on the first negedge after the load,
   // i.e. the first sample of the start bit.
   task automatic applyStimulus(input logic [7:0] b);
      thr_data = b;
      thr_wr   = 1'b1;
      tick(1);
      thr_wr   = 1'b0;
      brSync   = 1'b1;
      tick(1);
      brSync   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(2);
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_txd: got %b want 1", txd); end
      vectors++;
      if (thr_full !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_thr_full: got %b want 0", thr_full); end
      vectors++;
      if (thr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_thr_empty: got %b want 1", thr_empty); end
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_tsr_empty: got %b want 1", tsr_empty); end
      vectors++;
      if (tx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_overrun: got %b want 0", tx_overrun); end
      rst_n = 1'b1;
      tick(2);
   endtask

   // 0x55 8N1: alternating levels, each exactly 96 clocks, drained at 960.
   task automatic test_frame_8n1();
      logic [9:0] expBits;
      expBits = {1'b1, 8'h55, 1'b0};
      applyStimulus(8'h55);
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (txd !== expBits[k]) begin miscompares++; $display("[TB] FAIL 8n1_bit%0d_first: got %b want %b", k, txd, expBits[k]); end
         tick(BIT_CLKS - 1);
         vectors++;
         if (txd !== expBits[k]) begin miscompares++; $display("[TB] FAIL 8n1_bit%0d_last: got %b want %b", k, txd, expBits[k]); end
         if (k == 9) begin
            vectors++;
            if (tsr_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL 8n1_busy_959: tsr_empty=%b want 0", tsr_empty); end
         end
         tick(1);
      end
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL 8n1_drained_960: tsr_empty=%b want 1", tsr_empty); end
   endtask

   // 0x0B, 7 data bits, even parity (=1), 2 stop bits: 11 bits, 1056 clocks.
   task automatic test_parity_2stop();
      logic [10:0] expBits;
      expBits     = {2'b11, 1'b1, 7'h0B, 1'b0};
      word_len    = 2'b10;
      parity_en   = 1'b1;
      even_parity = 1'b1;
      stop_bits   = 1'b1;
      applyStimulus(8'h0B);
      tick(BIT_CLKS / 2);
      for (int k = 0; k < 11; k++) begin
         vectors++;
         if (txd !== expBits[k]) begin miscompares++; $display("[TB] FAIL par_bit%0d: got %b want %b", k, txd, expBits[k]); end
         if (k < 10) tick(BIT_CLKS);
      end
      tick(47);
      vectors++;
      if (tsr_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL par_busy_1055: tsr_empty=%b want 0", tsr_empty); end
      tick(1);
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL par_drained_1056: tsr_empty=%b want 1", tsr_empty); end
      word_len    = 2'b11;
      parity_en   = 1'b0;
      even_parity = 1'b0;
      stop_bits   = 1'b0;
   endtask

   // 0x1F, 5 bits, 1.5 stop: stop spans 24 ticks = 144 clocks, frame 720.
   task automatic test_stop_1p5();
      word_len  = 2'b00;
      stop_bits = 1'b1;
      applyStimulus(8'h1F);
      tick(BIT_CLKS - 1);
      vectors++;
      if (txd !== 1'b0) begin miscompares++; $display("[TB] FAIL s15_start_95: got %b want 0", txd); end
      tick(1);
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("[TB] FAIL s15_data0_96: got %b want 1", txd); end
      tick(479 + 144);
      vectors++;
      if (tsr_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL s15_busy_719: tsr_empty=%b want 0", tsr_empty); end
      tick(1);
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL s15_drained_720: tsr_empty=%b want 1", tsr_empty); end
      word_len  = 2'b11;
      stop_bits = 1'b0;
   endtask

   // 0xA5 shifting, 0x3C parked in THR, 0x77 dropped with an overrun pulse;
   // the two frames run back to back.
   task automatic test_back_to_back();
      logic [9:0] bitsA;
      logic [9:0] bitsB;
      bitsA = {1'b1, 8'hA5, 1'b0};
      bitsB = {1'b1, 8'h3C, 1'b0};
      applyStimulus(8'hA5);
      tick(10);
      thr_data = 8'h3C;
      thr_wr   = 1'b1;
      tick(1);
      thr_wr   = 1'b0;
      vectors++;
      if (thr_full !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_thr_full: got %b want 1", thr_full); end
      tick(9);
      thr_data = 8'h77;
      thr_wr   = 1'b1;
      #1;
      vectors++;
      if (tx_overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_overrun_on: got %b want 1", tx_overrun); end
      tick(1);
      thr_wr = 1'b0;
      #1;
      vectors++;
      if (tx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun_off: got %b want 0", tx_overrun); end
      tick(27);
      for (int k = 0; k < 9; k++) begin
         vectors++;
         if (txd !== bitsA[k]) begin miscompares++; $display("[TB] FAIL b2b_A5_bit%0d: got %b want %b", k, txd, bitsA[k]); end
         tick(BIT_CLKS);
      end
      tick(47);
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_stop_959: got %b want 1", txd); end
      tick(1);
      vectors++;
      if (txd !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_gap_960: got %b want 0", txd); end
      vectors++;
      if (thr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_thr_empty_960: got %b want 1", thr_empty); end
      tick(BIT_CLKS / 2);
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (txd !== bitsB[k]) begin miscompares++; $display("[TB] FAIL b2b_3C_bit%0d: got %b want %b", k, txd, bitsB[k]); end
         if (k < 9) tick(BIT_CLKS);
      end
      tick(47);
      vectors++;
      if (tsr_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_1919: tsr_empty=%b want 0", tsr_empty); end
      tick(1);
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_drained_1920: tsr_empty=%b want 1", tsr_empty); end
   endtask

   // Reset in the middle of a data bit, then a clean 0x81 frame.
   task automatic test_reset_mid_frame();
      logic [9:0] expBits;
      expBits = {1'b1, 8'h81, 1'b0};
      applyStimulus(8'h00);
      tick(5);
      thr_data = 8'h99;
      thr_wr   = 1'b1;
      tick(1);
      thr_wr   = 1'b0;
      tick(294);
      vectors++;
      if (txd !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_pre_txd: got %b want 0", txd); end
      rst_n = 1'b0;
      tick(1);
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_txd: got %b want 1", txd); end
      vectors++;
      if (thr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_thr_empty: got %b want 1", thr_empty); end
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_tsr_empty: got %b want 1", tsr_empty); end
      rst_n = 1'b1;
      applyStimulus(8'h81);
      tick(BIT_CLKS / 2);
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (txd !== expBits[k]) begin miscompares++; $display("[TB] FAIL rmid_81_bit%0d: got %b want %b", k, txd, expBits[k]); end
         if (k < 9) tick(BIT_CLKS);
      end
      tick(47);
      vectors++;
      if (tsr_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_busy_959: tsr_empty=%b want 0", tsr_empty); end
      tick(1);
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_drained_960: tsr_empty=%b want 1", tsr_empty); end
   endtask

   // Break held for 500 clocks inside a 0xFF frame; the frame timing is intact.
   task automatic test_break();
      int highs;
      highs = 0;
      applyStimulus(8'hFF);
      tick(100);
      break_ctrl = 1'b1;
      for (int i = 0; i < 500; i++) begin
         #1;
         if (txd !== 1'b0) highs++;
         tick(1);
      end
      vectors++;
      if (highs != 0) begin miscompares++; $display("[TB] FAIL brk_low: %0d high samples, want 0", highs); end
      break_ctrl = 1'b0;
      #1;
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("[TB] FAIL brk_release_600: got %b want 1", txd); end
      tick(359);
      vectors++;
      if (tsr_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL brk_busy_959: tsr_empty=%b want 0", tsr_empty); end
      tick(1);
      vectors++;
      if (tsr_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL brk_drained_960: tsr_empty=%b want 1", tsr_empty); end
      vectors++;
      if (txd !== 1'b1) begin miscompares++; $display("[TB] FAIL brk_idle_960: got %b want 1", txd); end
   endtask

`ifdef UART_TX_FIFO_EN
   // 17 back-to-back writes from idle: one goes to the shifter, 16 fill the FIFO.
   task automatic test_fifo_fill();
      int overruns;
      overruns = 0;
      for (int i = 0; i < 17; i++) begin
         thr_data = 8'(16 + i);
         thr_wr   = 1'b1;
         #1;
         if (tx_overrun !== 1'b0) overruns++;
         tick(1);
      end
      thr_wr = 1'b0;
      vectors++;
      if (overruns != 0) begin miscompares++; $display("[TB] FAIL fifo_overrun: %0d pulses, want 0", overruns); end
      vectors++;
      if (thr_full !== 1'b1) begin miscompares++; $display("[TB] FAIL fifo_full: got %b want 1", thr_full); end
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
   endtask
`endif

   // Test sequence.
   initial begin
      vectors      = 0;
      miscompares  = 0;
      brSync       = 1'b0;
      rst_n        = 1'b0;
      thr_data     = 8'h00;
      thr_wr       = 1'b0;
      word_len     = 2'b11;
      stop_bits    = 1'b0;
      parity_en    = 1'b0;
      even_parity  = 1'b0;
      stick_parity = 1'b0;
      break_ctrl   = 1'b0;
      test_reset();
      test_frame_8n1();
      test_parity_2stop();
      test_stop_1p5();
      test_back_to_back();
      test_reset_mid_frame();
      test_break();
`ifdef UART_TX_FIFO_EN
      test_fifo_fill();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; sits directly downstream of baud_gen and consumes its `br` tick.
- Double-buffered: a transmit holding register (THR) feeds a transmit shift register (TSR).
- Serializes one frame per byte, LSB first, 16550-style: start, 5–8 data bits, optional parity, 1/1.5/2 stop.
- Bit timing derived solely from `br`; no internal divider.

Parameters:
- OVERSAMPLE, 16, `br` ticks per serial bit; must be even and >= 4.
- FIFO_DEPTH, 16, TX FIFO entries; used only when UART_TX_FIFO_EN is defined; power of two.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- br, input, 1, one-clk-wide baud tick from baud_gen at OVERSAMPLE x baud rate.
- thr_data, input, 8, byte to transmit.
- thr_wr, input, 1, write strobe; one byte accepted per asserted clk.
- word_len, input, 2, data bits: 00=5, 01=6, 10=7, 11=8.
- stop_bits, input, 1, 0 = 1 stop bit; 1 = 2 stop bits (1.5 when word_len=00).
- parity_en, input, 1, parity bit inserted when 1.
- even_parity, input, 1, 1 = even parity, 0 = odd.
- stick_parity, input, 1, with parity_en: parity bit = ~even_parity.
- break_ctrl, input, 1, forces txd low while 1.
- txd, output, 1, serial out; idle high.
- thr_full, output, 1, holding storage cannot accept a write.
- thr_empty, output, 1, holding storage empty.
- tsr_empty, output, 1, shifter idle and holding storage empty (transmitter fully drained).
- tx_overrun, output, 1, one-clk pulse when a write is dropped because storage is full.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - txd=1, thr_full=0, thr_empty=1, tsr_empty=1, tx_overrun=0.
  - State IDLE; tick and bit counters cleared; holding storage cleared.
  - Reset mid-frame aborts the frame; txd=1 from the next edge.
- Write handling:
  - thr_wr with storage not full: byte stored.
  - thr_wr with storage full: byte dropped and tx_overrun=1 for that clk.
  - Write and TSR load in the same clk with THR full: the load frees the slot and the write is accepted, with no overrun.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START:
  - Occurs on the first clk where holding storage is non-empty, without waiting for `br`.
  - TSR loads the byte, and word_len/stop_bits/parity config is latched.
  - tick_cnt is cleared and txd=0 on the same edge.
  - Config changes mid-frame affect only the next frame.
- Bit timing:
  - tick_cnt increments on each clk with br=1.
  - A bit ends on the clk where br=1 and tick_cnt=OVERSAMPLE-1; tick_cnt then wraps to 0 and the next bit is driven on that edge.
- START -> DATA.
- DATA:
  - TSR shifts right; txd = TSR[0].
  - After 5+word_len bits: go to PARITY if parity_en, else STOP.
- PARITY bit value:
  - Non-stick: XOR of the sent data bits, inverted when even_parity=0.
  - Stick: ~even_parity.
- STOP:
  - txd=1.
  - Length 1, 2, or 1.5 bits; 1.5 bits = 3*OVERSAMPLE/2 ticks.
  - At stop end with storage non-empty: load the next byte and enter START on the same edge (back-to-back frames, no idle gap).
  - At stop end with storage empty: go to IDLE.
- tsr_empty = (state==IDLE) && thr_empty.
- break_ctrl:
  - Overrides txd to 0 combinationally after the registered value.
  - The FSM keeps running, so frames are lost while break is active.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined:
  - Holding storage is a FIFO_DEPTH-entry circular FIFO with wrapping read/write pointers and a count.
  - thr_full when count==FIFO_DEPTH; thr_empty when count==0.
  - Simultaneous write and pop at full: both occur, count unchanged.
- Undefined:
  - Holding storage is a single 8-bit THR plus valid flag.
  - thr_full = valid; thr_empty = ~valid.

Test Plan:
- Frame 0x55, 8N1, br every 6 clks (divisor 6):
  - txd = 0,1,0,1,0,1,0,1,0,1, each level held 96 clks.
  - tsr_empty returns to 1 at 960 clks after load.
- Frame 0x0B, 7 bits, even parity, 2 stop:
  - Data bits 1,1,0,1,0,0,0; parity = 1; two stop bits.
  - Total frame length = 11 bits.
- Frame 0x1F, word_len=00, stop_bits=1: stop phase lasts exactly 24 br ticks.
- Write 0xA5, then 0x3C, then 0x77 while the first is shifting (no FIFO):
  - 0x3C is held in THR.
  - 0x77 gives tx_overrun=1 for one clk.
  - 0xA5 and 0x3C frames are back-to-back, with no idle high beyond the stop bit.
- rst_n low mid-DATA:
  - Next edge: txd=1, thr_empty=1, tsr_empty=1.
  - A following write of 0x81 produces a full clean frame.
- break_ctrl=1 for 500 clks during a frame: txd=0 throughout; FSM reaches IDLE normally.
- With UART_TX_FIFO_EN: write 17 bytes back-to-back while idle:
  - First byte moves straight to TSR, leaving 16 bytes in the FIFO.
  - Bytes 2–17 fill it, so thr_full=1 and tx_overrun=0.
